// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_W    = 5;
    localparam int ZERO_REG = 31;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear that sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline registers and PC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int REG_W    = pipe_ctrl_pkg::REG_W,
    parameter int ZERO_REG = pipe_ctrl_pkg::ZERO_REG,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_err,
    output logic             busy
);

    import pipe_ctrl_pkg::*;

    // Timer only needs to reach TIMEOUT-1: the cycle that would reach TIMEOUT fires.
    localparam int c_TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_mem_err;

    logic                w_lu;
    logic                w_mw;
    logic                w_timeout;
    logic                w_pc_en;
    stage_ctrl_t         w_ifid;
    stage_ctrl_t         w_idex;
    stage_ctrl_t         w_exmem;
    stage_ctrl_t         w_memwb;

    assign w_lu = ex_mem_read && (ex_rd != REG_W'(ZERO_REG)) &&
                  ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
    assign w_mw = mem_req && !mem_ready;

    assign w_timeout = (TIMEOUT != 0) && (r_state == MEM_WAIT) && w_mw &&
                       (r_timer == c_TMR_W'(c_TMO_LAST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (w_mw)  w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (!w_mw) w_state_nxt = RUN;
            default:             w_state_nxt = RUN;
        endcase
    end

    // Freeze is decided from w_mw directly so it takes effect in the very first wait cycle.
    always_comb begin
        w_pc_en = 1'b1;
        w_ifid  = '{en: 1'b1, flush: 1'b0};
        w_idex  = '{en: 1'b1, flush: 1'b0};
        w_exmem = '{en: 1'b1, flush: 1'b0};
        w_memwb = '{en: 1'b1, flush: 1'b0};
        if (reset) begin
            w_pc_en = 1'b0;
            w_ifid  = '{en: 1'b1, flush: 1'b1};
            w_idex  = '{en: 1'b1, flush: 1'b1};
            w_exmem = '{en: 1'b1, flush: 1'b1};
            w_memwb = '{en: 1'b1, flush: 1'b1};
        end else if (w_mw) begin
            w_pc_en = 1'b0;
            w_ifid  = '{en: 1'b0, flush: 1'b0};
            w_idex  = '{en: 1'b0, flush: 1'b0};
            w_exmem = '{en: 1'b0, flush: 1'b0};
            w_memwb = '{en: 1'b0, flush: 1'b0};
        end else if (ex_br_taken) begin
            w_ifid  = '{en: 1'b1, flush: 1'b1};
            w_idex  = '{en: 1'b1, flush: 1'b1};
        end else if (w_lu) begin
            w_pc_en = 1'b0;
            w_ifid  = '{en: 1'b0, flush: 1'b0};
            w_idex  = '{en: 1'b1, flush: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_timer   <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == RUN) || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end else if (err_clr) begin
                r_mem_err <= 1'b0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!w_mw && !ex_br_taken && w_lu),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (!w_mw && ex_br_taken),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_mw),
        .count (wait_cnt)
    );

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid.en;
    assign ifid_flush  = w_ifid.flush;
    assign idex_en     = w_idex.en;
    assign idex_flush  = w_idex.flush;
    assign exmem_en    = w_exmem.en;
    assign exmem_flush = w_exmem.flush;
    assign memwb_en    = w_memwb.en;
    assign memwb_flush = w_memwb.flush;
    assign mem_err     = r_mem_err;
    assign busy        = (r_state == MEM_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Scoreboard bench for pipe_hazard_ctrl (CNT_W=4, TIMEOUT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int c_CNT_W   = 4;
    localparam int c_TIMEOUT = 8;
    localparam int c_ZERO    = 31;
    localparam int c_CMAX    = (1 << c_CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [4:0] id_rn = '0, id_rm = '0, ex_rd = '0;
    logic       id_use_rn = 0, id_use_rm = 0, ex_mem_read = 0, ex_br_taken = 0;
    logic       mem_req = 0, mem_ready = 0, err_clr = 0;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [c_CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic mem_err, busy;

    pipe_hazard_ctrl #(
        .REG_W(5), .ZERO_REG(c_ZERO), .CNT_W(c_CNT_W), .TIMEOUT(c_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
        .mem_err(mem_err), .busy(busy)
    );

    // ctrl = {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, busy, mem_err}
    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
        logic [31:0] wait_c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic m_busy = 0, m_err = 0;
    int   m_tcnt = 0, m_stall = 0, m_flush = 0, m_wait = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic f_lu();
        return ex_mem_read && (ex_rd != 5'(c_ZERO)) &&
               ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
    endfunction

    function automatic logic f_mw();
        return mem_req && !mem_ready;
    endfunction

    function automatic exp_t model_out();
        exp_t       e;
        logic [8:0] st;
        if (reset)            st = 9'b0_1111_1111;
        else if (f_mw())      st = 9'b0_0000_0000;
        else if (ex_br_taken) st = 9'b1_1111_1100;
        else if (f_lu())      st = 9'b0_0111_0100;
        else                  st = 9'b1_1111_0000;
        e.ctrl   = {st, m_busy, m_err};
        e.stall  = 32'(m_stall);
        e.flush  = 32'(m_flush);
        e.wait_c = 32'(m_wait);
        return e;
    endfunction

    task automatic model_step();
        logic mw, fire;
        mw   = f_mw();
        fire = 1'b0;
        if (reset) begin
            m_busy = 0; m_err = 0; m_tcnt = 0;
            m_stall = 0; m_flush = 0; m_wait = 0;
        end else begin
            if (mw)                 m_wait  = (m_wait  < c_CMAX) ? m_wait  + 1 : c_CMAX;
            else if (ex_br_taken)   m_flush = (m_flush < c_CMAX) ? m_flush + 1 : c_CMAX;
            else if (f_lu())        m_stall = (m_stall < c_CMAX) ? m_stall + 1 : c_CMAX;
            if (!m_busy) begin
                m_tcnt = 0;
            end else if (mw) begin
                m_tcnt++;
                if (m_tcnt == c_TIMEOUT) begin
                    fire   = 1'b1;
                    m_tcnt = 0;
                end
            end
            if (fire)         m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_busy = mw;
        end
    endtask

    task automatic cycle();
        exp_t e;
        q.push_back(model_out());
        @(negedge clk);
        e = q.pop_front();
        chk("ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush, busy, mem_err}, 32'(e.ctrl));
        chk("stall_cnt", 32'(stall_cnt), e.stall);
        chk("flush_cnt", 32'(flush_cnt), e.flush);
        chk("wait_cnt",  32'(wait_cnt),  e.wait_c);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle();
        id_rn = '0; id_rm = '0; ex_rd = '0;
        id_use_rn = 0; id_use_rm = 0; ex_mem_read = 0; ex_br_taken = 0;
        mem_req = 0; mem_ready = 0; err_clr = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rn = rd; id_use_rn = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        cycle();
        chk("reset_pc_en", 32'(pc_en), 32'd0);
        reset = 0;
        cycles(2);

        // Load-use via rn, then through the zero register, then via rm
        set_lu(5'd3);  cycle(); idle(); cycle();
        chk("stall_after_lu", 32'(stall_cnt), 32'd1);
        set_lu(5'd31); cycle(); idle(); cycle();
        chk("stall_zero_reg", 32'(stall_cnt), 32'd1);
        ex_mem_read = 1; ex_rd = 5'd7; id_rm = 5'd7; id_use_rm = 1; cycle();
        id_use_rm = 0; cycle(); idle(); cycle();
        chk("stall_rm", 32'(stall_cnt), 32'd2);

        // Branch overrides load-use
        set_lu(5'd3); ex_br_taken = 1; cycle(); idle(); cycle();
        chk("flush_after_br", 32'(flush_cnt), 32'd1);

        // Memory freeze with pending branch
        mem_req = 1; mem_ready = 0; ex_br_taken = 1; cycles(4);
        mem_ready = 1; cycle();
        idle(); cycles(2);
        chk("wait_after_freeze", 32'(wait_cnt), 32'd4);
        chk("flush_after_freeze", 32'(flush_cnt), 32'd2);

        // Timeout, clear, re-set
        mem_req = 1; mem_ready = 0; cycles(12);
        chk("mem_err_set", 32'(mem_err), 32'd1);
        err_clr = 1; cycle(); err_clr = 0; cycle();
        chk("mem_err_cleared", 32'(mem_err), 32'd0);
        cycles(8);
        chk("mem_err_reset", 32'(mem_err), 32'd1);

        // Reset while waiting
        reset = 1; cycle();
        reset = 0; idle(); cycle();
        chk("busy_after_rst", 32'(busy), 32'd0);
        chk("wait_after_rst", 32'(wait_cnt), 32'd0);
        chk("err_after_rst", 32'(mem_err), 32'd0);

        // Saturation
        set_lu(5'd3); cycles(20); idle(); cycle();
        chk("stall_saturated", 32'(stall_cnt), 32'(c_CMAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
